regfile_scoreboard: RTL

- Parametrised general-purpose register file for the next-generation pipelined core.
- Configurable data width, depth and number of read ports, with optional write-to-read bypass and a hardwired-zero register.
- Adds a per-register busy scoreboard: set at issue, cleared at writeback, drop-all on flush, plus a registered outstanding-producer count.
- Sits between decode (reads, issue) and writeback (write port).

---
 rtl/regfile_scoreboard.sv | 98 +++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, optional write bypass and hardwired zero,
// plus a per-register busy scoreboard and a registered count of outstanding producers.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_addr,
    input  logic                         flush,
    output logic [ADDR_W:0]              busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              wr_ok;
    logic              issue_ok;
    logic              inc;
    logic              dec;
    logic [ADDR_W-1:0] rd_idx;

    // Writes and issues aimed at the hardwired zero register are discarded up front.
    assign wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr    == '0));
    assign issue_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

    // A same-register issue+writeback keeps the bit set, so the writeback must not decrement.
    assign inc = issue_ok && !busy_q[issue_addr];
    assign dec = wr_ok && busy_q[wr_addr] && !(issue_ok && (issue_addr == wr_addr));

    always_comb begin
        busy_d  = busy_q;
        count_d = count_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[issue_addr] = 1'b1;
        end
        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_addr] <= wr_data;
            end
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Zero register wins over bypass, which wins over stored contents.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_idx  = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            rd_idx = rd_addr[k*ADDR_W +: ADDR_W];
            rd_data[k*DATA_W +: DATA_W] = mem_q[rd_idx];
            rd_busy[k] = busy_q[rd_idx];
            if ((BYPASS != 0) && wr_en && (wr_addr == rd_idx)) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
                rd_busy[k] = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_idx == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k] = 1'b0;
            end
        end
    end

    assign busy_count = count_q;

endmodule
